mac_accumulator_hhrb98: RTL and testbench

- Downstream stage of the 4x4 array multiplier.
- Consumes the 8-bit product stream `p` and sums N consecutive products into one frame result, which it presents on a valid/ready output.
- Applications: dot products and multiply-accumulate on small operands.
- Sequential. Single clock domain, shared with the multiplier's `clk`.

---
 rtl/mac_accumulator_hhrb98_if.sv | 24 ++
 rtl/mac_accumulator_hhrb98.sv | 93 +++++++++
 tb/tb_mac_accumulator_hhrb98.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mac_accumulator_hhrb98_if.sv
// Product-in and frame-result-out valid/ready bundle.
// slave: the accumulator; master: producer/consumer side.
interface mac_accumulator_hhrb98_if #(
  parameter int PW = 8,
  parameter int AW = 12
);
  logic [PW-1:0] p_in;
  logic          p_valid;
  logic          p_ready;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          acc_ready;
  logic          ovf;

  modport master (
    output p_in, p_valid, acc_ready,
    input  p_ready, acc_out, acc_valid, ovf
  );

  modport slave (
    input  p_in, p_valid, acc_ready,
    output p_ready, acc_out, acc_valid, ovf
  );
endinterface

// File: rtl/mac_accumulator_hhrb98.sv
// Sums N consecutive products into one saturating frame result.
// Ports: clk, rst (sync high), clear, bus (slave), cnt (products so far).
module mac_accumulator_hhrb98 #(
  parameter int PW = 8,
  parameter int AW = 12,
  parameter int N  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  mac_accumulator_hhrb98_if.slave bus,
  output logic [7:0] cnt
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [AW-1:0] MAXV = '1;
  localparam logic [7:0]    LAST = 8'(N - 1);

  state_t        state;
  logic [AW-1:0] acc;
  logic [7:0]    cnt_q;
  logic          sticky;

  logic [AW:0]   sum;
  logic          sat;
  logic [AW-1:0] acc_nxt;
  logic          ovf_nxt;
  logic          rdy;
  logic          accept;
  logic          hs;

  // One extra bit catches the carry that signals saturation.
  always_comb begin
    sum     = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, bus.p_in};
    sat     = sum[AW];
    acc_nxt = sat ? MAXV : sum[AW-1:0];
    ovf_nxt = sticky | sat;
  end

  assign rdy         = (state == ACCUM) && !rst && !clear;
  assign bus.p_ready = rdy;
  assign accept      = bus.p_valid && rdy;
  assign hs          = bus.acc_valid && bus.acc_ready;
  assign cnt         = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACCUM;
      acc           <= '0;
      cnt_q         <= '0;
      sticky        <= 1'b0;
      bus.acc_out   <= '0;
      bus.ovf       <= 1'b0;
      bus.acc_valid <= 1'b0;
    end else if (clear) begin
      // acc_out/ovf are left as-is; acc_valid low marks them stale.
      state         <= ACCUM;
      acc           <= '0;
      cnt_q         <= '0;
      sticky        <= 1'b0;
      bus.acc_valid <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            if (cnt_q == LAST) begin
              bus.acc_out   <= acc_nxt;
              bus.ovf       <= ovf_nxt;
              bus.acc_valid <= 1'b1;
              state         <= HOLD;
              acc           <= '0;
              cnt_q         <= '0;
              sticky        <= 1'b0;
            end else begin
              acc    <= acc_nxt;
              sticky <= ovf_nxt;
              cnt_q  <= cnt_q + 8'd1;
            end
          end
        end
        HOLD: begin
          if (hs) begin
            bus.acc_valid <= 1'b0;
            state         <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator_hhrb98.sv
// Bench for mac_accumulator_hhrb98: default and (AW=10,N=5) builds.
// Both share stimulus; a frame-level model predicts each cycle.
module tb_mac_accumulator_hhrb98;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  always #5 clk = ~clk;

  mac_accumulator_hhrb98_if #(.PW(8), .AW(12)) ifa ();
  mac_accumulator_hhrb98_if #(.PW(8), .AW(10)) ifb ();

  mac_accumulator_hhrb98 #(.PW(8), .AW(12), .N(4)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (ifa.slave),
    .cnt   (cnt_a)
  );

  mac_accumulator_hhrb98 #(.PW(8), .AW(10), .N(5)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (ifb.slave),
    .cnt   (cnt_b)
  );

  int checks = 0;
  int errors = 0;

  // Model: running unclamped total and count; clamp at frame end.
  int nn [2] = '{4, 5};
  int mx [2] = '{4095, 1023};
  int m_tot  [2];
  int m_cnt  [2];
  int m_out  [2];
  bit m_ovf  [2];
  bit m_hold [2];

  task automatic chk(input string tag, input int k,
                     input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s dut%0d got %0d exp %0d", tag, k, got, exp);
    end
  endtask

  task automatic chk_all(input logic r, input logic c);
    bit er;
    for (int k = 0; k < 2; k++) begin
      er = !r && !c && !m_hold[k];
      if (k == 0) begin
        chk("p_ready", 0, 16'(ifa.p_ready), 16'(er));
        chk("acc_valid", 0, 16'(ifa.acc_valid), 16'(m_hold[0]));
        chk("cnt", 0, 16'(cnt_a), 16'(m_cnt[0]));
        chk("acc_out", 0, 16'(ifa.acc_out), 16'(m_out[0]));
        chk("ovf", 0, 16'(ifa.ovf), 16'(m_ovf[0]));
      end else begin
        chk("p_ready", 1, 16'(ifb.p_ready), 16'(er));
        chk("acc_valid", 1, 16'(ifb.acc_valid), 16'(m_hold[1]));
        chk("cnt", 1, 16'(cnt_b), 16'(m_cnt[1]));
        chk("acc_out", 1, 16'(ifb.acc_out), 16'(m_out[1]));
        chk("ovf", 1, 16'(ifb.ovf), 16'(m_ovf[1]));
      end
    end
  endtask

  task automatic model(input logic r, input logic c, input logic v,
                       input int d, input logic ar);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_hold[k] = 0; m_tot[k] = 0; m_cnt[k] = 0;
        m_out[k] = 0; m_ovf[k] = 0;
      end else if (c) begin
        m_hold[k] = 0; m_tot[k] = 0; m_cnt[k] = 0;
      end else if (m_hold[k]) begin
        if (ar) m_hold[k] = 0;
      end else if (v) begin
        m_tot[k] += d;
        m_cnt[k]++;
        if (m_cnt[k] == nn[k]) begin
          m_out[k]  = (m_tot[k] > mx[k]) ? mx[k] : m_tot[k];
          m_ovf[k]  = m_tot[k] > mx[k];
          m_hold[k] = 1;
          m_tot[k]  = 0;
          m_cnt[k]  = 0;
        end
      end
    end
  endtask

  // Drive after the edge, check settled outputs, then advance model.
  task automatic cyc(input logic c, input logic r, input logic v,
                     input int d, input logic ar);
    @(posedge clk);
    #1;
    clear = c;
    rst   = r;
    ifa.p_valid   = v;
    ifb.p_valid   = v;
    ifa.p_in      = v ? 8'(d) : 8'bx;
    ifb.p_in      = v ? 8'(d) : 8'bx;
    ifa.acc_ready = ar;
    ifb.acc_ready = ar;
    #1;
    chk_all(r, c);
    model(r, c, v, d, ar);
  endtask

  int pv [7] = '{1, 0, 0, 1, 1, 0, 1};
  int pd [7] = '{10, 0, 0, 20, 30, 0, 40};
  int f2 [4] = '{6, 0, 9, 1};

  initial begin
    ifa.p_valid = 0; ifb.p_valid = 0;
    ifa.p_in = 0; ifb.p_in = 0;
    ifa.acc_ready = 0; ifb.acc_ready = 0;
    for (int k = 0; k < 2; k++) begin
      m_tot[k] = 0; m_cnt[k] = 0; m_out[k] = 0;
      m_ovf[k] = 0; m_hold[k] = 0;
    end

    // Full-scale frame
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 225, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t1_out", 0, 16'(ifa.acc_out), 16'd900);
    chk("t1_valid", 0, 16'(ifa.acc_valid), 16'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t1_pulse", 0, 16'(ifa.acc_valid), 16'd0);

    // Held result with back-pressure
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, f2[i], 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 3, 0);
    chk("t2_hold", 0, 16'(ifa.acc_out), 16'd16);
    cyc(0, 0, 1, 3, 1);
    cyc(0, 0, 1, 3, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t2_cnt", 0, 16'(cnt_a), 16'd1);

    // Saturation on narrow build, sticky cleared per frame
    cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 225, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t3_sat", 1, 16'(ifb.acc_out), 16'd1023);
    chk("t3_ovf", 1, 16'(ifb.ovf), 16'd1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t3_out2", 1, 16'(ifb.acc_out), 16'd5);
    chk("t3_ovf2", 1, 16'(ifb.ovf), 16'd0);

    // Irregular valid
    cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 7; i++) cyc(0, 0, pv[i][0], pd[i], 1);
    cyc(0, 0, 0, 0, 1);
    chk("t4_out", 0, 16'(ifa.acc_out), 16'd100);

    // Clear drops the offered product
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 1, 50, 1);
    cyc(0, 0, 1, 60, 1);
    cyc(1, 0, 1, 70, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t5_out", 0, 16'(ifa.acc_out), 16'd4);

    // Reset while holding
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 7, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t6_pre", 0, 16'(ifa.acc_valid), 16'd1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t6_valid", 0, 16'(ifa.acc_valid), 16'd0);
    chk("t6_out", 0, 16'(ifa.acc_out), 16'd0);
    chk("t6_ready", 0, 16'(ifa.p_ready), 16'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 79) == 0),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)));
    end
    cyc(0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
